// File: rtl/lsu_pkg.sv
// Shared types and store-formatting helper for the load/store sequencer.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } lsu_state_e;

    localparam logic [STRB_W-1:0] STRB_WORD = 4'hF;
    localparam logic [STRB_W-1:0] STRB_NONE = 4'h0;

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [STRB_W-1:0] strb;
    } mem_wr_t;

    // Loads carry no strobes; sb replicates the byte and selects one lane.
    function automatic mem_wr_t fmt_store(input logic            is_load,
                                          input logic            is_byte,
                                          input logic [1:0]      offset,
                                          input logic [XLEN-1:0] wdata);
        mem_wr_t r;
        r.data = wdata;
        r.strb = STRB_WORD;
        if (is_byte) begin
            r.data = {4{wdata[7:0]}};
            r.strb = STRB_W'(4'b0001 << offset);
        end
        if (is_load) begin
            r.strb = STRB_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/load_store_seq.sv
// Multi-cycle lw/lbu/sw/sb sequencer between decode and the data RAM.
// Optional MISALIGN_TRAP_EN: misaligned word ops are dropped and flagged on err_misalign.
module load_store_seq
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_load,
    input  logic              op_byte,
    input  logic [XLEN-1:0]   op_addr,
    input  logic [XLEN-1:0]   op_wdata,
    input  logic [REG_W-1:0]  op_rd,
    output logic              busy,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [XLEN-1:0]   wb_ramout,
    output logic [1:0]        wb_addr10,
    output logic              wb_lwlbu,
`ifdef MISALIGN_TRAP_EN
    output logic              err_misalign,
`endif
    output logic              err_timeout
);

    localparam bit               TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    lsu_state_e        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              load_q, load_d;
    logic              to_hit;
    mem_wr_t           fmt;

    logic              op_ready_d, busy_d, mem_req_valid_d, mem_we_d;
    logic [XLEN-1:0]   mem_addr_d, mem_wdata_d, wb_ramout_d;
    logic [STRB_W-1:0] mem_wstrb_d;
    logic              wb_valid_d, wb_lwlbu_d, err_timeout_d;
    logic [REG_W-1:0]  wb_rd_d;
    logic [1:0]        wb_addr10_d;
`ifdef MISALIGN_TRAP_EN
    logic              err_misalign_d;
    logic              misalign_c;

    assign misalign_c = ~op_byte & (op_addr[1:0] != 2'b00);
`endif

    assign to_hit = TO_EN && (cnt == TO_LAST);
    assign fmt    = fmt_store(op_load, op_byte, op_addr[1:0], op_wdata);

    // Next-state and next-output decode; every registered output is staged here.
    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        load_d          = load_q;
        mem_we_d        = mem_we;
        mem_addr_d      = mem_addr;
        mem_wdata_d     = mem_wdata;
        mem_wstrb_d     = mem_wstrb;
        wb_rd_d         = wb_rd;
        wb_ramout_d     = wb_ramout;
        wb_addr10_d     = wb_addr10;
        wb_lwlbu_d      = wb_lwlbu;
        err_timeout_d   = err_timeout;
`ifdef MISALIGN_TRAP_EN
        err_misalign_d  = 1'b0;
`endif

        unique case (state)
            IDLE: begin
                if (op_valid) begin
`ifdef MISALIGN_TRAP_EN
                    if (misalign_c) begin
                        err_misalign_d = 1'b1;
                    end else
`endif
                    begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        load_d      = op_load;
                        mem_we_d    = ~op_load;
                        mem_addr_d  = {op_addr[XLEN-1:2], 2'b00};
                        mem_wdata_d = fmt.data;
                        mem_wstrb_d = fmt.strb;
                        wb_rd_d     = op_rd;
                        wb_addr10_d = op_addr[1:0];
                        wb_lwlbu_d  = op_byte;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt + CNT_W'(1);
                if (to_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt + CNT_W'(1);
                if (to_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else if (mem_rsp_valid) begin
                    if (load_q) begin
                        wb_ramout_d = mem_rdata;
                        state_d     = WB;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        op_ready_d      = (state_d == IDLE);
        busy_d          = ~op_ready_d;
        mem_req_valid_d = (state_d == REQ);
        wb_valid_d      = (state_d == WB);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            load_q        <= 1'b0;
            op_ready      <= 1'b1;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= STRB_NONE;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_ramout     <= '0;
            wb_addr10     <= '0;
            wb_lwlbu      <= 1'b0;
            err_timeout   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            err_misalign  <= 1'b0;
`endif
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            load_q        <= load_d;
            op_ready      <= op_ready_d;
            busy          <= busy_d;
            mem_req_valid <= mem_req_valid_d;
            mem_we        <= mem_we_d;
            mem_addr      <= mem_addr_d;
            mem_wdata     <= mem_wdata_d;
            mem_wstrb     <= mem_wstrb_d;
            wb_valid      <= wb_valid_d;
            wb_rd         <= wb_rd_d;
            wb_ramout     <= wb_ramout_d;
            wb_addr10     <= wb_addr10_d;
            wb_lwlbu      <= wb_lwlbu_d;
            err_timeout   <= err_timeout_d;
`ifdef MISALIGN_TRAP_EN
            err_misalign  <= err_misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_seq.sv
// Directed self-checking bench for load_store_seq (default instance plus a TIMEOUT_CYC=4 instance).
module tb_load_store_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_load, op_byte;
    logic [31:0] op_addr, op_wdata, mem_rdata;
    logic [4:0]  op_rd;
    logic        mem_req_ready, mem_rsp_valid;

    logic        op_ready, busy, mem_req_valid, mem_we, wb_valid, wb_lwlbu, err_timeout;
    logic [31:0] mem_addr, mem_wdata, wb_ramout;
    logic [3:0]  mem_wstrb;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_addr10;

    logic        t_op_valid, t_mem_req_ready, t_mem_rsp_valid;
    logic        t_op_ready, t_busy, t_mem_req_valid, t_mem_we, t_wb_valid, t_wb_lwlbu, t_err_timeout;
    logic [31:0] t_mem_addr, t_mem_wdata, t_wb_ramout;
    logic [3:0]  t_mem_wstrb;
    logic [4:0]  t_wb_rd;
    logic [1:0]  t_wb_addr10;
`ifdef MISALIGN_TRAP_EN
    logic        err_misalign, t_err_misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_seq dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_load(op_load), .op_byte(op_byte),
        .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd), .busy(busy),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_ramout(wb_ramout), .wb_addr10(wb_addr10),
        .wb_lwlbu(wb_lwlbu),
`ifdef MISALIGN_TRAP_EN
        .err_misalign(err_misalign),
`endif
        .err_timeout(err_timeout)
    );

    load_store_seq #(.TIMEOUT_CYC(4), .CNT_W(8)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .op_valid(t_op_valid), .op_ready(t_op_ready), .op_load(op_load), .op_byte(op_byte),
        .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd), .busy(t_busy),
        .mem_req_valid(t_mem_req_valid), .mem_req_ready(t_mem_req_ready), .mem_we(t_mem_we),
        .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_wstrb(t_mem_wstrb),
        .mem_rsp_valid(t_mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(t_wb_valid), .wb_rd(t_wb_rd), .wb_ramout(t_wb_ramout), .wb_addr10(t_wb_addr10),
        .wb_lwlbu(t_wb_lwlbu),
`ifdef MISALIGN_TRAP_EN
        .err_misalign(t_err_misalign),
`endif
        .err_timeout(t_err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic present(input logic ld, input logic bt, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd);
        op_valid = 1'b1;
        op_load  = ld;
        op_byte  = bt;
        op_addr  = addr;
        op_wdata = wd;
        op_rd    = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        op_valid = 1'b0; op_load = 1'b0; op_byte = 1'b0;
        op_addr = '0; op_wdata = '0; op_rd = '0; mem_rdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        t_op_valid = 1'b0; t_mem_req_ready = 1'b0; t_mem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);

        // reset values
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_wstrb", 32'(mem_wstrb), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // lw 0x104, RAM ready immediately, response next cycle
        present(1'b1, 1'b0, 32'h104, 32'h0, 5'd5);
        mem_req_ready = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        check("lw_req_valid", 32'(mem_req_valid), 32'd1);
        check("lw_mem_addr", mem_addr, 32'h104);
        check("lw_wstrb", 32'(mem_wstrb), 32'h0);
        check("lw_we", 32'(mem_we), 32'd0);
        check("lw_busy", 32'(busy), 32'd1);
        check("lw_op_ready", 32'(op_ready), 32'd0);
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("lw_wait_req_valid", 32'(mem_req_valid), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("lw_wb_valid", 32'(wb_valid), 32'd1);
        check("lw_wb_ramout", wb_ramout, 32'hDEADBEEF);
        check("lw_wb_addr10", 32'(wb_addr10), 32'd0);
        check("lw_wb_rd", 32'(wb_rd), 32'd5);
        check("lw_wb_lwlbu", 32'(wb_lwlbu), 32'd0);
        @(negedge clk);
        check("lw_wb_pulse", 32'(wb_valid), 32'd0);
        check("lw_idle", 32'(op_ready), 32'd1);

        // lbu 0x207
        present(1'b1, 1'b1, 32'h207, 32'h0, 5'd9);
        mem_req_ready = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        check("lbu_mem_addr", mem_addr, 32'h204);
        check("lbu_wstrb", 32'(mem_wstrb), 32'h0);
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h11223344;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("lbu_wb_valid", 32'(wb_valid), 32'd1);
        check("lbu_wb_addr10", 32'(wb_addr10), 32'd3);
        check("lbu_wb_lwlbu", 32'(wb_lwlbu), 32'd1);
        check("lbu_wb_ramout", wb_ramout, 32'h11223344);
        check("lbu_wb_rd", 32'(wb_rd), 32'd9);
        @(negedge clk);

        // sb 0x302 data 0xA5: replicated byte, lane 2, back in IDLE after 3 cycles
        present(1'b0, 1'b1, 32'h302, 32'h000000A5, 5'd0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        check("sb_we", 32'(mem_we), 32'd1);
        check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        check("sb_wstrb", 32'(mem_wstrb), 32'h4);
        check("sb_mem_addr", mem_addr, 32'h300);
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("sb_op_ready", 32'(op_ready), 32'd1);
        check("sb_no_wb", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check("sb_no_wb_late", 32'(wb_valid), 32'd0);

        // sw 0x400 with RAM stalled 5 cycles; response coincident with handshake ignored
        present(1'b0, 1'b0, 32'h400, 32'h12345678, 5'd0);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_valid = 1'b0;
            check("stall_req_valid", 32'(mem_req_valid), 32'd1);
            check("stall_mem_addr", mem_addr, 32'h400);
            check("stall_wdata", mem_wdata, 32'h12345678);
            check("stall_wstrb", 32'(mem_wstrb), 32'hF);
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_op_ready", 32'(op_ready), 32'd0);
        end
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        check("early_rsp_ignored_busy", 32'(busy), 32'd1);
        check("early_rsp_req_done", 32'(mem_req_valid), 32'd0);
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("sw_done", 32'(op_ready), 32'd1);

        // misaligned word op
        present(1'b1, 1'b0, 32'h106, 32'h0, 5'd3);
        mem_req_ready = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        check("mis_err", 32'(err_misalign), 32'd1);
        check("mis_no_req", 32'(mem_req_valid), 32'd0);
        check("mis_op_ready", 32'(op_ready), 32'd1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("mis_err_pulse", 32'(err_misalign), 32'd0);
`else
        check("mis_mem_addr", mem_addr, 32'h104);
        check("mis_req_valid", 32'(mem_req_valid), 32'd1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hCAFE0001;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("mis_wb_valid", 32'(wb_valid), 32'd1);
        check("mis_wb_addr10", 32'(wb_addr10), 32'd2);
        @(negedge clk);
`endif

        // async reset while in WAIT drops the load
        present(1'b1, 1'b0, 32'h500, 32'h0, 5'd7);
        mem_req_ready = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rstw_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_op_ready", 32'(op_ready), 32'd1);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_req_valid", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("rstw_no_wb", 32'(wb_valid), 32'd0);
        check("rstw_idle", 32'(op_ready), 32'd1);
        @(negedge clk);
        check("rstw_no_wb_late", 32'(wb_valid), 32'd0);

        // TIMEOUT_CYC=4: one REQ cycle, then WAIT with no response
        present(1'b1, 1'b0, 32'h600, 32'h0, 5'd1);
        op_valid = 1'b0;
        t_op_valid = 1'b1;
        @(negedge clk);
        t_op_valid = 1'b0;
        check("to_c1_err", 32'(t_err_timeout), 32'd0);
        check("to_c1_req", 32'(t_mem_req_valid), 32'd1);
        t_mem_req_ready = 1'b1;
        @(negedge clk);
        t_mem_req_ready = 1'b0;
        check("to_c2_err", 32'(t_err_timeout), 32'd0);
        check("to_c2_wait", 32'(t_mem_req_valid), 32'd0);
        @(negedge clk);
        check("to_c3_err", 32'(t_err_timeout), 32'd0);
        @(negedge clk);
        check("to_c4_err", 32'(t_err_timeout), 32'd0);
        check("to_c4_busy", 32'(t_busy), 32'd1);
        @(negedge clk);
        check("to_err_set", 32'(t_err_timeout), 32'd1);
        check("to_idle", 32'(t_op_ready), 32'd1);
        check("to_busy", 32'(t_busy), 32'd0);
        t_mem_rsp_valid = 1'b1;
        @(negedge clk);
        t_mem_rsp_valid = 1'b0;
        check("to_no_wb", 32'(t_wb_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("to_sticky", 32'(t_err_timeout), 32'd1);
        check("to_no_wb_late", 32'(t_wb_valid), 32'd0);
        check("dflt_no_timeout", 32'(err_timeout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
